regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file writeback arbiter: round-robin between execute (req0) and load (req1)
// writebacks, one registered write per cycle. Optional conflict counter under RF_WARB_STATS_EN.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  last_grant
`ifdef RF_WARB_STATS_EN
    ,
    output logic [15:0]           conflict_count
`endif
);

    logic                  w_both;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last_grant;

    assign w_both = req0_valid & req1_valid;

    // On a conflict the requester that did not win last time is served.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset && !stall) begin
            if (w_both) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_accept   = w_grant0 | w_grant1;
    assign w_sel_addr = w_grant1 ? req1_addr : req0_addr;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    // x0 is hardwired: the request is consumed but never strobed into the file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_we <= w_accept && (w_sel_addr != '0);
            if (w_accept) begin
                r_addr       <= w_sel_addr;
                r_data       <= w_sel_data;
                r_last_grant <= w_grant1;
            end
        end
    end

`ifdef RF_WARB_STATS_EN
    logic [15:0] r_conflict_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if (w_both && !stall) begin
            r_conflict_count <= sat_inc16(r_conflict_count);
        end
    end

    assign conflict_count = r_conflict_count;
`endif

    assign req0_ready   = w_grant0;
    assign req1_ready   = w_grant1;
    assign write_enable = r_we;
    assign addr_rd      = r_addr;
    assign data_rd      = r_data;
    assign last_grant   = r_last_grant;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        write_enable;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        last_grant;
`ifdef RF_WARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: what the outputs should show after the most recent edge.
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_lg;
    int          m_cc;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd), .last_grant(last_grant)
`ifdef RF_WARB_STATS_EN
        , .conflict_count(conflict_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_lg = 1; m_cc = 0;
    endtask

    // Inputs are already driven; check mid-cycle, then advance the model across one edge.
    task automatic step();
        int winner;
        @(negedge clock);
        winner = -1;
        if (!stall) begin
            if (req0_valid && req1_valid) winner = 1 - m_lg;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        chk("req0_ready", req0_ready, winner == 0);
        chk("req1_ready", req1_ready, winner == 1);
        chk("write_enable", write_enable, m_we);
        chk("addr_rd", addr_rd, m_addr);
        chk("data_rd", data_rd, m_data);
        chk("last_grant", last_grant, m_lg[0]);
`ifdef RF_WARB_STATS_EN
        chk("conflict_count", conflict_count, m_cc);
`endif
        if (req0_valid && req1_valid && !stall && m_cc < 65535) m_cc++;
        if (winner >= 0) begin
            m_addr = (winner == 1) ? req1_addr : req0_addr;
            m_data = (winner == 1) ? req1_data : req0_data;
            m_we   = (m_addr != 0);
            m_lg   = winner;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_addr", addr_rd, 5'd0);
        chk("rst_data", data_rd, 32'd0);
        chk("rst_lg", last_grant, 1'b1);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; stall = 1'b0;
    endtask

    initial begin
        logic saved_lg;
        model_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clock);
        #1;
        do_reset();
        idle();

        // Single request
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        step();
        chk("single_we", write_enable, 1'b1);
        chk("single_addr", addr_rd, 5'd5);
        chk("single_data", data_rd, 32'hDEADBEEF);
        idle();
        step();
        chk("single_we_drop", write_enable, 1'b0);

        // Conflict right after reset: req0, req1, req0
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        step(); chk("conf1_addr", addr_rd, 5'd3);
        step(); chk("conf2_addr", addr_rd, 5'd7);
        step(); chk("conf3_addr", addr_rd, 5'd3); chk("conf3_we", write_enable, 1'b1);
`ifdef RF_WARB_STATS_EN
        chk("conf_count", conflict_count, 16'd3);
`endif
        idle();
        step();

        // Write to x0
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1;
        step();
        chk("x0_we", write_enable, 1'b0);
        chk("x0_addr", addr_rd, 5'd0);
        chk("x0_lg", last_grant, 1'b1);
        idle();
        step();

        // Stall with both valid, then release
        saved_lg = last_grant;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hB1;
        stall = 1'b1;
        step(); step();
        chk("stall_lg", last_grant, saved_lg);
        chk("stall_we", write_enable, 1'b0);
        stall = 1'b0;
        step();
        chk("unstall_addr", addr_rd, 5'd10);
        idle();
        step();

        // Reset asserted between a handshake request and its edge
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        @(negedge clock);
        chk("pre_rst_ready", req0_ready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ready", req0_ready, 1'b0);
        @(posedge clock);
        #1;
        chk("async_we", write_enable, 1'b0);
        chk("async_addr", addr_rd, 5'd0);
        chk("async_lg", last_grant, 1'b1);
        reset = 1'b0;
        model_reset();
        idle();

        // Reset arriving while a registered write is on the outputs
        req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'hC;
        step();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("async2_we", write_enable, 1'b0);
        chk("async2_data", data_rd, 32'd0);
        chk("async2_lg", last_grant, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            stall      = ($urandom_range(0, 99) < 15);
            req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            req0_data  = $urandom;
            req1_data  = $urandom;
            step();
        end
        idle();
        step();

`ifdef RF_WARB_STATS_EN
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_count", conflict_count, 16'hFFFF);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
